// File: rtl/blastit_daylight_tx.sv
// blastit_daylight_tx: daylight sensor synchronizer/debouncer with UART (8N1) change reporting.
// Each debounced state change queues one ASCII report byte: 'D' (0x44) for day, 'N' (0x4E)
// for night. Changes arriving while a frame is on the line coalesce into one follow-up frame.
// Optional feature: define BLASTIT_DAYLIGHT_HEARTBEAT_EN to re-report the current state every
// 2^26 cycles even without a change.
module blastit_daylight_tx #(
    parameter int unsigned CLK_HZ          = 50000000,
    parameter int unsigned BAUD            = 115200,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic DAYLIGHT,
    output logic UART_TX,
    output logic TX_BUSY,
    output logic DAY_STATE,
    output logic WARN
);

    localparam int unsigned BaudDiv = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned BaudW   = (BaudDiv > 1) ? $clog2(BaudDiv) : 1;
    localparam int unsigned DebW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(BaudDiv - 1);
    localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

    logic            sync1_q, sync2_q;
    logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
    logic            day_q, day_d;
    logic            warn_q;
    logic            pending_q, pending_d;
    logic            change;
    logic            hb_tick;

    tx_state_e        state_q, state_d;
    logic [BaudW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       byte_q, byte_d;
    logic             tx_q, tx_d;
    logic             frame_start;
    logic             baud_done;

`ifdef BLASTIT_DAYLIGHT_HEARTBEAT_EN
    logic [25:0] hb_cnt_q;

    // Free-running heartbeat counter; a tick fires once per wrap.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            hb_cnt_q <= '0;
        end else begin
            hb_cnt_q <= hb_cnt_q + 26'd1;
        end
    end

    assign hb_tick = &hb_cnt_q;
`else
    assign hb_tick = 1'b0;
`endif

    // Two-flop synchronizer for the asynchronous sensor input.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= DAYLIGHT;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive cycles the synchronized level differs from the accepted state.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        day_d     = day_q;
        change    = 1'b0;
        if (sync2_q == day_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DebLast) begin
            day_d     = ~day_q;
            deb_cnt_d = '0;
            change    = 1'b1;
        end else begin
            deb_cnt_d = deb_cnt_q + DebW'(1);
        end
    end

    // Report request: a frame start consumes it, but a same-cycle change or heartbeat re-arms it.
    always_comb begin
        pending_d = pending_q;
        if (frame_start) begin
            pending_d = 1'b0;
        end
        if (change || hb_tick) begin
            pending_d = 1'b1;
        end
    end

    // Debounce, warning and pending state registers.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            deb_cnt_q <= '0;
            day_q     <= 1'b0;
            warn_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            day_q     <= day_d;
            warn_q    <= day_q;
            pending_q <= pending_d;
        end
    end

    assign baud_done = (baud_cnt_q == BaudLast);

    // UART transmit FSM next-state and registered line level.
    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_idx_d   = bit_idx_q;
        byte_d      = byte_q;
        tx_d        = tx_q;
        frame_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                tx_d       = 1'b1;
                baud_cnt_d = '0;
                if (pending_q) begin
                    frame_start = 1'b1;
                    state_d     = StStart;
                    // Byte reflects the state at frame start, so coalesced changes report latest.
                    byte_d      = day_q ? 8'h44 : 8'h4E;
                    tx_d        = 1'b0;
                end
            end
            StStart: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = 3'd0;
                    state_d    = StData;
                    tx_d       = byte_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q + BaudW'(1);
                end
            end
            StData: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = byte_q[bit_idx_d];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BaudW'(1);
                end
            end
            StStop: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    state_d    = StIdle;
                    tx_d       = 1'b1;
                end else begin
                    baud_cnt_d = baud_cnt_q + BaudW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Transmit FSM registers; reset forces the line high immediately.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_idx_q  <= 3'd0;
            byte_q     <= 8'h00;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_q     <= byte_d;
            tx_q       <= tx_d;
        end
    end

    assign UART_TX   = tx_q;
    assign TX_BUSY   = (state_q != StIdle);
    assign DAY_STATE = day_q;
    assign WARN      = warn_q;

endmodule

// File: tb/tb_blastit_daylight_tx.sv
// Directed testbench for blastit_daylight_tx with BAUD_DIV = 10 and a 4-cycle debounce.
module tb_blastit_daylight_tx;

    logic clk;
    logic rst;
    logic daylight;
    logic uart_tx;
    logic tx_busy;
    logic day_state;
    logic warn;

    int checks = 0;
    int errors = 0;

    blastit_daylight_tx #(
        .CLK_HZ          (1000),
        .BAUD            (100),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .CLOCK_50  (clk),
        .RESET     (rst),
        .DAYLIGHT  (daylight),
        .UART_TX   (uart_tx),
        .TX_BUSY   (tx_busy),
        .DAY_STATE (day_state),
        .WARN      (warn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Watch n cycles; count cycles where the line goes low or DAY_STATE differs from day_exp.
    task automatic quiet(input string tag, input int n, input logic day_exp);
        int lows;
        int days;
        lows = 0;
        days = 0;
        for (int i = 0; i < n; i++) begin
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) lows++;
            if (day_state !== day_exp) days++;
            step(1);
        end
        chk({tag, " line idle cycles bad"}, lows, 0);
        chk({tag, " day_state cycles bad"}, days, 0);
    endtask

    // Called 1 ns after the start-bit edge; checks all 100 frame cycles, optionally changing
    // DAYLIGHT at frame cycle t1/t2, and checks the idle cycle after the stop bit.
    task automatic check_frame(input logic [7:0] b, input string tag,
                               input int t1, input logic l1, input int t2, input logic l2);
        logic [9:0] bits;
        int bad;
        bits = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            bad = 0;
            for (int c = 0; c < 10; c++) begin
                if (k * 10 + c == t1) daylight = l1;
                if (k * 10 + c == t2) daylight = l2;
                if (uart_tx !== bits[k] || tx_busy !== 1'b1) bad++;
                step(1);
            end
            chk($sformatf("%s bit%0d bad cycles", tag, k), bad, 0);
        end
        chk({tag, " busy after stop"}, {31'd0, tx_busy}, 0);
        chk({tag, " line after stop"}, {31'd0, uart_tx}, 1);
    endtask

    initial begin
        // Reset held, then released with night input.
        rst      = 1'b1;
        daylight = 1'b0;
        step(3);
        chk("reset uart_tx", {31'd0, uart_tx}, 1);
        chk("reset tx_busy", {31'd0, tx_busy}, 0);
        chk("reset day_state", {31'd0, day_state}, 0);
        chk("reset warn", {31'd0, warn}, 0);
        rst = 1'b0;
        quiet("post-reset", 200, 1'b0);
        chk("post-reset warn", {31'd0, warn}, 0);

        // Night to day: toggle at edge 6, start bit at edge 7, frame 'D'.
        daylight = 1'b1;
        step(5);
        chk("edge5 day_state", {31'd0, day_state}, 0);
        step(1);
        chk("edge6 day_state", {31'd0, day_state}, 1);
        chk("edge6 warn", {31'd0, warn}, 0);
        chk("edge6 uart_tx", {31'd0, uart_tx}, 1);
        step(1);
        chk("edge7 uart_tx", {31'd0, uart_tx}, 0);
        chk("edge7 tx_busy", {31'd0, tx_busy}, 1);
        chk("edge7 warn", {31'd0, warn}, 1);
        check_frame(8'h44, "first D", -1, 1'b0, -1, 1'b0);
        quiet("after D", 30, 1'b1);

        // 3-cycle night glitch is rejected.
        daylight = 1'b0;
        step(3);
        daylight = 1'b1;
        quiet("glitch", 30, 1'b1);

        // Day to night, then back to day 20 cycles into the 'N' frame.
        daylight = 1'b0;
        step(6);
        chk("night day_state", {31'd0, day_state}, 0);
        step(1);
        chk("night start bit", {31'd0, uart_tx}, 0);
        check_frame(8'h4E, "N frame", 20, 1'b1, -1, 1'b0);
        step(1);
        chk("b2b start bit", {31'd0, uart_tx}, 0);
        // Two opposite changes within this frame, ending at day.
        check_frame(8'h44, "b2b D", 10, 1'b0, 40, 1'b1);
        step(1);
        chk("coalesced start bit", {31'd0, uart_tx}, 0);
        check_frame(8'h44, "coalesced D", -1, 1'b0, -1, 1'b0);
        quiet("after coalesce", 150, 1'b1);

        // Reset during data bit 3 of a 'D' frame (bit 3 of 0x44 is 0).
        daylight = 1'b0;
        step(7);
        chk("pre-abort N start", {31'd0, uart_tx}, 0);
        check_frame(8'h4E, "pre-abort N", -1, 1'b0, -1, 1'b0);
        step(5);
        daylight = 1'b1;
        step(7);
        chk("abort D start", {31'd0, uart_tx}, 0);
        step(45);
        chk("abort bit3 low", {31'd0, uart_tx}, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("abort uart_tx", {31'd0, uart_tx}, 1);
        chk("abort tx_busy", {31'd0, tx_busy}, 0);
        chk("abort day_state", {31'd0, day_state}, 0);
        chk("abort warn", {31'd0, warn}, 0);
        daylight = 1'b0;
        step(3);
        rst = 1'b0;
        quiet("after abort", 50, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
